// File: rtl/conv_pkg.sv
// Shared types and widths for the 1x1 convolution sequencer.
// Used by conv_1x1_seq and conv_seq_loopcnt.
package conv_pkg;

    localparam int GROUP_CH = 8;
    localparam int PIX_W    = 16;
    localparam int GRP_W    = 8;
    localparam int PERF_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [PIX_W-1:0] pixels;
        logic [GRP_W-1:0] cin;
        logic [GRP_W-1:0] cout;
    } cfg_t;

    function automatic logic cfg_valid(input cfg_t c);
        return (c.pixels != '0) && (c.cin != '0) && (c.cout != '0);
    endfunction

endpackage

// File: rtl/conv_seq_loopcnt.sv
// Nested og/pix/cg loop counters for the 1x1 conv sequencer.
// cg is innermost, og outermost; wrap flags mark the last index.
module conv_seq_loopcnt
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             adv,
    input  logic [GRP_W-1:0] cin_max,
    input  logic [PIX_W-1:0] pix_max,
    input  logic [GRP_W-1:0] cout_max,
    output logic [GRP_W-1:0] cg,
    output logic [PIX_W-1:0] pix,
    output logic [GRP_W-1:0] og,
    output logic             cg_wrap,
    output logic             pix_wrap,
    output logic             og_wrap
);

    logic [GRP_W-1:0] cg_q, cg_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [GRP_W-1:0] og_q, og_d;

    assign cg       = cg_q;
    assign pix      = pix_q;
    assign og       = og_q;
    assign cg_wrap  = (cg_q == cin_max);
    assign pix_wrap = (pix_q == pix_max);
    assign og_wrap  = (og_q == cout_max);

    always_comb begin
        cg_d  = cg_q;
        pix_d = pix_q;
        og_d  = og_q;
        if (clear) begin
            cg_d  = '0;
            pix_d = '0;
            og_d  = '0;
        end else if (adv) begin
            if (!cg_wrap) begin
                cg_d = cg_q + 1'b1;
            end else begin
                cg_d = '0;
                if (!pix_wrap) begin
                    pix_d = pix_q + 1'b1;
                end else begin
                    pix_d = '0;
                    og_d  = og_wrap ? '0 : og_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cg_q  <= '0;
            pix_q <= '0;
            og_q  <= '0;
        end else begin
            cg_q  <= cg_d;
            pix_q <= pix_d;
            og_q  <= og_d;
        end
    end

endmodule

// File: rtl/conv_1x1_seq.sv
// 1x1 convolution job sequencer: issues pixel/weight reads, tracks results.
// Define CONV_SEQ_PERF_EN to add perf_cycles/perf_stalls counters.
module conv_1x1_seq
    import conv_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MAX_OUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PIX_W-1:0]  cfg_pixels,
    input  logic [GRP_W-1:0]  cfg_cin_grp,
    input  logic [GRP_W-1:0]  cfg_cout_grp,
    input  logic              stall,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              wt_rd,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [GRP_W-1:0]  bias_addr,
    output logic              conv_valid_in,
    output logic              conv_last_channel,
    input  logic              conv_data_valid,
    output logic              busy,
    output logic              done
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_stalls
`endif
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    state_e           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    cfg_t             cfg_in;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             room;
    logic             issue;
    logic             inc;
    logic             dec;
    logic             last_beat;

    logic [GRP_W-1:0] cg;
    logic [PIX_W-1:0] pix;
    logic [GRP_W-1:0] og;
    logic             cg_wrap;
    logic             pix_wrap;
    logic             og_wrap;

    logic [ADDR_W-1:0] pa;
    logic [ADDR_W-1:0] wa;

    assign cfg_in = '{pixels: cfg_pixels,
                      cin:    cfg_cin_grp,
                      cout:   cfg_cout_grp};

    assign accept    = (state_q == S_IDLE) && start;
    assign room      = (outst_q != OUT_W'(MAX_OUT));
    assign issue     = (state_q == S_RUN) && !stall && room;
    assign inc       = issue && cg_wrap;
    assign dec       = conv_data_valid && (outst_q != '0);
    assign last_beat = cg_wrap && pix_wrap && og_wrap;

    conv_seq_loopcnt u_loopcnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .adv      (issue),
        .cin_max  (cfg_q.cin - 8'd1),
        .pix_max  (cfg_q.pixels - 16'd1),
        .cout_max (cfg_q.cout - 8'd1),
        .cg       (cg),
        .pix      (pix),
        .og       (og),
        .cg_wrap  (cg_wrap),
        .pix_wrap (pix_wrap),
        .og_wrap  (og_wrap)
    );

    // Products wrap at ADDR_W bits by construction of the casts.
    assign pa = ADDR_W'(pix) * ADDR_W'(cfg_q.cin) + ADDR_W'(cg);
    assign wa = ADDR_W'(og) * ADDR_W'(cfg_q.cin) + ADDR_W'(cg);

    assign pix_rd            = issue;
    assign wt_rd             = issue;
    assign pix_addr          = issue ? pa : '0;
    assign wt_addr           = issue ? wa : '0;
    assign bias_addr         = og;
    assign conv_valid_in     = vld_q;
    assign conv_last_channel = last_q;
    assign busy              = busy_q;
    assign done              = done_q;

    always_comb begin
        outst_d = outst_q;
        if (accept) begin
            outst_d = '0;
        end else if (inc && !dec) begin
            outst_d = outst_q + 1'b1;
        end else if (dec && !inc) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_valid(cfg_in)) begin
                        state_d = S_RUN;
                        cfg_d   = cfg_in;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (issue && last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Wait for the delayed last beat and every result.
                if ((outst_d == '0) && !vld_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign vld_d  = issue;
    assign last_d = issue && cg_wrap;
    assign busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    assign done_d = (state_d == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            outst_q <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            outst_q <= outst_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CONV_SEQ_PERF_EN
    logic [PERF_W-1:0] pcyc_q, pcyc_d;
    logic [PERF_W-1:0] pstl_q, pstl_d;

    always_comb begin
        pcyc_d = pcyc_q;
        pstl_d = pstl_q;
        if (accept) begin
            pcyc_d = '0;
            pstl_d = '0;
        end else begin
            if (busy_q && (pcyc_q != '1)) begin
                pcyc_d = pcyc_q + 1'b1;
            end
            if ((state_q == S_RUN) && !issue && (pstl_q != '1)) begin
                pstl_d = pstl_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcyc_q <= '0;
            pstl_q <= '0;
        end else begin
            pcyc_q <= pcyc_d;
            pstl_q <= pstl_d;
        end
    end

    assign perf_cycles = pcyc_q;
    assign perf_stalls = pstl_q;
`endif

endmodule

// File: tb/tb_conv_1x1_seq.sv
// Directed bench for conv_1x1_seq (ADDR_W=8, MAX_OUT=2).
// Models a conv array returning one result per last beat, 1 cycle late.
module tb_conv_1x1_seq;

    localparam int AW = 8;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   cfg_pixels;
    logic [7:0]    cfg_cin_grp;
    logic [7:0]    cfg_cout_grp;
    logic          stall;
    logic          pix_rd;
    logic [AW-1:0] pix_addr;
    logic          wt_rd;
    logic [AW-1:0] wt_addr;
    logic [7:0]    bias_addr;
    logic          conv_valid_in;
    logic          conv_last_channel;
    logic          conv_data_valid;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    conv_1x1_seq #(.ADDR_W(AW), .MAX_OUT(MO)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_pixels        (cfg_pixels),
        .cfg_cin_grp       (cfg_cin_grp),
        .cfg_cout_grp      (cfg_cout_grp),
        .stall             (stall),
        .pix_rd            (pix_rd),
        .pix_addr          (pix_addr),
        .wt_rd             (wt_rd),
        .wt_addr           (wt_addr),
        .bias_addr         (bias_addr),
        .conv_valid_in     (conv_valid_in),
        .conv_last_channel (conv_last_channel),
        .conv_data_valid   (conv_data_valid),
        .busy              (busy),
        .done              (done)
    );

    typedef struct {
        int pix;
        int cin;
        int cout;
        int beats;
        int lasts;
        int lpix;
        int lwt;
        int lbias;
    } vec_t;

    vec_t vt[7];

    int n_chk = 0;
    int n_pass = 0;

    int beats, vlds, lasts, dones, stall_issues, viol, owed;
    int last_pix, last_wt, last_bias, last_mask;
    int pix_seq[$];
    int wt_seq[$];
    logic hold;
    logic prev_rd;

    // Monitor and conv-array model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            conv_data_valid = 1'b0;
            if (!rst) begin
                prev_rd = 1'b0;
            end else begin
                if (conv_valid_in !== prev_rd) viol++;
                if (conv_last_channel && !conv_valid_in) viol++;
                if (pix_rd !== wt_rd) viol++;
                if (conv_valid_in) begin
                    if (conv_last_channel) begin
                        lasts++;
                        if (vlds < 31) last_mask |= (1 << vlds);
                    end
                    vlds++;
                end
                if (pix_rd) begin
                    beats++;
                    pix_seq.push_back(int'(pix_addr));
                    wt_seq.push_back(int'(wt_addr));
                    last_pix  = int'(pix_addr);
                    last_wt   = int'(wt_addr);
                    last_bias = int'(bias_addr);
                    if (stall) stall_issues++;
                end
                if (done) dones++;
                prev_rd = pix_rd;
                if (!hold && owed > 0) begin
                    conv_data_valid = 1'b1;
                    owed--;
                end
                if (conv_valid_in && conv_last_channel) owed++;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic clear_stats();
        beats = 0;
        vlds = 0;
        lasts = 0;
        dones = 0;
        stall_issues = 0;
        viol = 0;
        last_mask = 0;
        last_pix = -1;
        last_wt = -1;
        last_bias = -1;
        pix_seq.delete();
        wt_seq.delete();
    endtask

    task automatic start_job(input int p, input int ci, input int co);
        @(posedge clk);
        #1;
        clear_stats();
        cfg_pixels   = 16'(p);
        cfg_cin_grp  = 8'(ci);
        cfg_cout_grp = 8'(co);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int cyc);
        bit got = 0;
        cyc = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                cyc = i;
                break;
            end
        end
        chk({nm, "_done_seen"}, got, 1);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [29:0] out_bus();
        return {pix_rd, wt_rd, pix_addr, wt_addr, bias_addr,
                conv_valid_in, conv_last_channel, busy, done};
    endfunction

    int cyc;
    int exp_pix[12];
    int exp_wt[12];

    initial begin
        vt[0] = '{1, 1, 1, 1, 1, 0, 0, 0};
        vt[1] = '{2, 3, 2, 12, 4, 5, 5, 1};
        vt[2] = '{3, 2, 1, 6, 3, 5, 1, 0};
        vt[3] = '{1, 2, 3, 6, 3, 1, 5, 2};
        vt[4] = '{4, 1, 2, 8, 8, 3, 1, 1};
        vt[5] = '{3, 100, 1, 300, 3, 43, 99, 0};
        vt[6] = '{1, 100, 3, 300, 3, 99, 43, 2};
        exp_pix = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
        exp_wt  = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};

        rst = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        hold = 1'b0;
        owed = 0;
        conv_data_valid = 1'b0;
        cfg_pixels = '0;
        cfg_cin_grp = '0;
        cfg_cout_grp = '0;
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", longint'(out_bus()), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int k = 0; k < 7; k++) begin
            start_job(vt[k].pix, vt[k].cin, vt[k].cout);
            wait_done($sformatf("v%0d", k), cyc);
            chk($sformatf("v%0d_beats", k), beats, vt[k].beats);
            chk($sformatf("v%0d_lasts", k), lasts, vt[k].lasts);
            chk($sformatf("v%0d_lpix", k), last_pix, vt[k].lpix);
            chk($sformatf("v%0d_lwt", k), last_wt, vt[k].lwt);
            chk($sformatf("v%0d_lbias", k), last_bias, vt[k].lbias);
            chk($sformatf("v%0d_dones", k), dones, 1);
            chk($sformatf("v%0d_viol", k), viol, 0);
            chk($sformatf("v%0d_busy", k), busy, 0);
        end

        start_job(1, 1, 1);
        wait_done("lat", cyc);
        chk("lat_cycles", cyc, 3);
        chk("lat_mask", last_mask, 1);

        start_job(2, 3, 2);
        wait_done("seq", cyc);
        chk("seq_len", pix_seq.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("seq_pix%0d", i),
                (i < pix_seq.size()) ? pix_seq[i] : -1, exp_pix[i]);
            chk($sformatf("seq_wt%0d", i),
                (i < wt_seq.size()) ? wt_seq[i] : -1, exp_wt[i]);
        end
        chk("seq_mask", last_mask, 32'h924);

        start_job(2, 3, 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        stall = 1'b1;
        @(negedge clk);
        chk("stall_inflight", conv_valid_in, 1);
        chk("stall_no_rd", pix_rd, 0);
        repeat (5) @(posedge clk);
        #1;
        stall = 1'b0;
        wait_done("stall", cyc);
        chk("stall_issues", stall_issues, 0);
        chk("stall_beats", beats, 12);
        chk("stall_lasts", lasts, 4);
        chk("stall_viol", viol, 0);

        hold = 1'b1;
        start_job(4, 1, 1);
        repeat (6) @(negedge clk);
        chk("maxout_halt", beats, 2);
        chk("maxout_busy", busy, 1);
        @(posedge clk);
        #1;
        hold = 1'b0;
        wait_done("maxout", cyc);
        chk("maxout_beats", beats, 4);
        chk("maxout_lasts", lasts, 4);
        chk("maxout_dones", dones, 1);

        start_job(5, 2, 0);
        wait_done("zero_cout", cyc);
        chk("zero_cout_cyc", cyc, 0);
        chk("zero_cout_beats", beats, 0);
        chk("zero_cout_dones", dones, 1);
        start_job(0, 4, 4);
        wait_done("zero_pix", cyc);
        chk("zero_pix_beats", beats, 0);

        start_job(2, 3, 2);
        repeat (3) @(posedge clk);
        #1;
        cfg_pixels = 16'd1;
        cfg_cin_grp = 8'd1;
        cfg_cout_grp = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_start", cyc);
        chk("busy_start_beats", beats, 12);
        chk("busy_start_lwt", last_wt, 5);
        chk("busy_start_dones", dones, 1);

        start_job(2, 3, 2);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs", longint'(out_bus()), 0);
        repeat (2) @(posedge clk);
        #1;
        owed = 0;
        chk("rst_hold_valid", conv_valid_in, 0);
        rst = 1'b1;
        start_job(2, 3, 2);
        wait_done("after_rst", cyc);
        chk("after_rst_beats", beats, 12);
        chk("after_rst_lasts", lasts, 4);
        chk("after_rst_lwt", last_wt, 5);
        chk("after_rst_dones", dones, 1);
        chk("after_rst_viol", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
